// File: rtl/core_pkg.sv
// Shared fetch-front-end types: FSM encoding, fetch packet layout and reset defaults.
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;
   localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [XLEN-1:0] INSTR_BYTES  = 32'd4;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register for one fetched instruction and its PC.
module fetch_out_buf
   import core_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  fetch_pkt_t load_pkt,
   input  logic       pop,
   output logic       valid,
   output fetch_pkt_t pkt
);

   // Clear wins over load so a redirect never lets a stale word through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pkt   <= '0;
      end else begin
         if (clear) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
         end else if (pop) begin
            valid <= 1'b0;
         end
         if (load && !clear) begin
            pkt <= load_pkt;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem FSM, EX redirect and flush.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC instead of being aligned.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic [31:0] ex_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        misalign_exc,
   output logic [31:0] misalign_addr
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect;
   logic            buf_load;
   logic            buf_valid;
   fetch_pkt_t      buf_pkt;
   fetch_pkt_t      rsp_pkt;

   assign redirect = rst_n & ex_valid & ex_branch;

`ifdef MISALIGN_TRAP_EN
   logic misalign;

   assign misalign    = redirect & (ex_target[1:0] != 2'b00);
   assign redirect_pc = misalign ? TRAP_VEC : ex_target;

   // One-cycle trap pulse; the offending address is held until the next trap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_exc  <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_exc <= misalign;
         if (misalign) begin
            misalign_addr <= ex_target;
         end
      end
   end
`else
   assign redirect_pc   = ex_target & ~XLEN'(3);
   assign misalign_exc  = 1'b0;
   assign misalign_addr = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // WAIT is only entered after an un-redirected accept, so pc_q is always request PC + 4 there.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      buf_load       = 1'b0;
      imem_req_valid = 1'b0;
      unique case (state_q)
         ST_REQ: begin
            imem_req_valid = rst_n & (!buf_valid | if_ready);
            if (imem_req_valid && imem_req_ready) begin
               state_d = redirect ? ST_KILL : ST_WAIT;
               pc_d    = pc_q + INSTR_BYTES;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               state_d  = ST_REQ;
               buf_load = !redirect;
            end else if (redirect) begin
               state_d = ST_KILL;
            end
         end
         ST_KILL: begin
            if (imem_rsp_valid) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
      if (redirect) begin
         pc_d = redirect_pc;
      end
   end

   assign rsp_pkt = '{pc: pc_q - INSTR_BYTES, instr: imem_rsp_data};

   fetch_out_buf u_out_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (redirect),
      .load     (buf_load),
      .load_pkt (rsp_pkt),
      .pop      (buf_valid & if_ready),
      .valid    (buf_valid),
      .pkt      (buf_pkt)
   );

   assign imem_req_addr = pc_q;
   assign if_valid      = buf_valid & !redirect;
   assign if_pc         = buf_pkt.pc;
   assign if_instr      = buf_pkt.instr;
   assign flush_ifid    = redirect;
   assign flush_idex    = redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset-in-flight sequence, random run vs stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_branch;
   logic [31:0] ex_target;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_instr;
   logic        flush_ifid, flush_idex;
   logic        misalign_exc;
   logic [31:0] misalign_addr;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_target(ex_target),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
   );

   localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif
   localparam logic [31:0] MIS_PC = MIS_EN ? TRAP : 32'h0000_0200;

   int errs = 0;
   int checks = 0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed, address-unique word per location.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic drive(input bit rdy, input bit rv, input logic [31:0] rdata, input bit ir,
                        input bit ev, input bit eb, input logic [31:0] tgt);
      imem_req_ready = rdy;
      imem_rsp_valid = rv;
      imem_rsp_data  = rdata;
      if_ready       = ir;
      ex_valid       = ev;
      ex_branch      = eb;
      ex_target      = tgt;
   endtask

   typedef struct {
      bit rdy, rv; logic [31:0] rdata; bit ir, ev, eb; logic [31:0] tgt;
      bit e_rv; logic [31:0] e_ra; bit e_iv; logic [31:0] e_ipc; bit e_fl, e_exc; logic [31:0] e_maddr;
   } vec_t;

   function automatic vec_t mk(bit rdy, bit rv, logic [31:0] rdata, bit ir, bit ev, bit eb,
                               logic [31:0] tgt, bit erv, logic [31:0] era, bit eiv,
                               logic [31:0] eipc, bit efl, bit eexc, logic [31:0] emaddr);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ir = ir; v.ev = ev; v.eb = eb; v.tgt = tgt;
      v.e_rv = erv; v.e_ra = era; v.e_iv = eiv; v.e_ipc = eipc; v.e_fl = efl;
      v.e_exc = eexc; v.e_maddr = emaddr;
      return v;
   endfunction

   vec_t vecs[$];

   // Random-phase memory and stream model state.
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   logic [31:0] exp_pc, exp_req, maddr_exp, nt;
   bit          exc_exp, redir;
   int          delivered;

   initial begin
      // One row per cycle after reset release: inputs, then expected outputs.
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h0,  1'b0,0,     1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h0),1'b1,1'b0,1'b0,0, 1'b0,32'h4, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h4,  1'b1,32'h0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h4),1'b1,1'b0,1'b0,0, 1'b0,32'h8, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h8,  1'b1,32'h4, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h8),1'b1,1'b0,1'b0,0, 1'b0,32'hC, 1'b0,0, 1'b0,1'b0,0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1'b1,1'b0,0,1'b0,1'b0,1'b0,0, 1'b0,32'hC, 1'b1,32'h8, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'hC,  1'b1,32'h8, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b1,1'b1,32'h200, 1'b0,32'h10, 1'b0,0, 1'b1,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'hC),1'b1,1'b0,1'b0,0, 1'b0,32'h200, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h200, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h200, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h200),1'b1,1'b1,1'b1,32'h200, 1'b0,32'h204, 1'b0,0, 1'b1,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h200, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h200),1'b1,1'b0,1'b0,0, 1'b0,32'h204, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b0,1'b0,1'b0,0, 1'b0,32'h204, 1'b1,32'h200, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b1,32'h400, 1'b0,32'h204, 1'b0,0, 1'b1,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b0,1'b0,1'b0,0, 1'b1,32'h400, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h400),1'b0,1'b0,1'b0,0, 1'b0,32'h404, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h404, 1'b1,32'h400, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b1,1'b1,32'h500, 1'b1,32'h404, 1'b0,0, 1'b1,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h404),1'b1,1'b0,1'b0,0, 1'b0,32'h500, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b1,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h500, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'h500),1'b1,1'b0,1'b0,0, 1'b0,32'h504, 1'b0,0, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h504, 1'b1,32'h500, 1'b0,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b1,32'h202, 1'b1,32'h504, 1'b0,0, 1'b1,1'b0,0));
      vecs.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0,0, 1'b1,MIS_PC, 1'b0,0, 1'b0,1'b1,32'h202));
      vecs.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0,0, 1'b1,MIS_PC, 1'b0,0, 1'b0,1'b0,32'h202));
      vecs.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b1,32'hFFFF_FFFC, 1'b1,MIS_PC, 1'b0,0, 1'b1,1'b0,32'h202));
      vecs.push_back(mk(1'b1,1'b0,0,1'b0,1'b0,1'b0,0, 1'b1,32'hFFFF_FFFC, 1'b0,0, 1'b0,1'b0,32'h202));
      vecs.push_back(mk(1'b0,1'b1,instr_of(32'hFFFF_FFFC),1'b0,1'b0,1'b0,0, 1'b0,32'h0, 1'b0,0, 1'b0,1'b0,32'h202));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b0,1'b0,0, 1'b1,32'h0, 1'b1,32'hFFFF_FFFC, 1'b0,1'b0,32'h202));
      vecs.push_back(mk(1'b0,1'b0,0,1'b1,1'b0,1'b1,32'h700, 1'b1,32'h0, 1'b0,0, 1'b0,1'b0,32'h202));

      // Reset state, with a redirect presented to confirm it is ignored.
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h300);
      repeat (3) @(negedge clk);
      chk1 ("rst_req_valid", imem_req_valid, 1'b0);
      chk32("rst_req_addr",  imem_req_addr,  32'h0);
      chk1 ("rst_if_valid",  if_valid,       1'b0);
      chk1 ("rst_flush_ifid", flush_ifid,    1'b0);
      chk1 ("rst_flush_idex", flush_idex,    1'b0);
      chk1 ("rst_misalign_exc", misalign_exc, 1'b0);
      chk32("rst_misalign_addr", misalign_addr, 32'h0);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].ir, vecs[i].ev, vecs[i].eb, vecs[i].tgt);
         @(negedge clk);
         chk1 ($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
         chk32($sformatf("vec%0d_req_addr", i),  imem_req_addr,  vecs[i].e_ra);
         chk1 ($sformatf("vec%0d_if_valid", i),  if_valid,       vecs[i].e_iv);
         if (vecs[i].e_iv) begin
            chk32($sformatf("vec%0d_if_pc", i),    if_pc,    vecs[i].e_ipc);
            chk32($sformatf("vec%0d_if_instr", i), if_instr, instr_of(vecs[i].e_ipc));
         end
         chk1 ($sformatf("vec%0d_flush_ifid", i), flush_ifid, vecs[i].e_fl);
         chk1 ($sformatf("vec%0d_flush_idex", i), flush_idex, vecs[i].e_fl);
         chk1 ($sformatf("vec%0d_misalign_exc", i), misalign_exc, vecs[i].e_exc & MIS_EN);
         chk32($sformatf("vec%0d_misalign_addr", i), misalign_addr, MIS_EN ? vecs[i].e_maddr : 32'h0);
      end

      // Reset while a request is outstanding; the late response must be ignored.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk1 ("midrst_accept", imem_req_valid, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h600);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk1 ("midrst_req_valid", imem_req_valid, 1'b0);
      chk32("midrst_req_addr",  imem_req_addr,  32'h0);
      chk1 ("midrst_flush",     flush_ifid,     1'b0);
      chk1 ("midrst_if_valid",  if_valid,       1'b0);
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, instr_of(32'h0), 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk1 ("late_rsp_req_valid", imem_req_valid, 1'b1);
      chk32("late_rsp_req_addr",  imem_req_addr,  32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk1 ("late_rsp_dropped",   if_valid,       1'b0);
      chk32("late_rsp_addr_hold", imem_req_addr,  32'h0);

      // Random run: delivered PCs must form a contiguous stream restarted at each redirect target.
      pend = 1'b0; pend_cnt = 0; pend_addr = 0;
      exp_pc = 32'h0; exp_req = 32'h0; maddr_exp = 32'h0; exc_exp = 1'b0; delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         if_ready       = ($urandom_range(0, 9) < 7);
         ex_valid       = 1'($urandom_range(0, 1));
         ex_branch      = ($urandom_range(0, 15) == 0);
         ex_target      = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) != 0) ex_target[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) ex_target[31:12] = 20'hFFFFF;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (pend) begin
            if (pend_cnt <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = instr_of(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         @(negedge clk);
         redir = ex_valid & ex_branch;
         chk1 ("rnd_flush_ifid", flush_ifid, redir);
         chk1 ("rnd_flush_idex", flush_idex, redir);
         chk1 ("rnd_misalign_exc", misalign_exc, exc_exp);
         chk32("rnd_misalign_addr", misalign_addr, maddr_exp);
         exc_exp = 1'b0;
         if (redir) chk1("rnd_if_valid_on_redirect", if_valid, 1'b0);
         if (if_valid && if_ready) begin
            chk32("rnd_if_pc", if_pc, exp_pc);
            chk32("rnd_if_instr", if_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (imem_req_valid && imem_req_ready) begin
            chk32("rnd_req_addr", imem_req_addr, exp_req);
            chk1 ("rnd_single_outstanding", pend, 1'b0);
            exp_req   = exp_req + 32'd4;
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_cnt  = int'($urandom_range(1, 3));
         end
         if (redir) begin
            if (MIS_EN && ex_target[1:0] != 2'b00) begin
               nt        = TRAP;
               exc_exp   = 1'b1;
               maddr_exp = ex_target;
            end else begin
               nt = ex_target & ~32'h3;
            end
            exp_pc  = nt;
            exp_req = nt;
         end
      end
      chk1("rnd_progress", delivered >= 100, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
